load_store_sequencer: RTL and testbench

//  MEM-stage load/store sequencer placed directly upstream of the byte-wide data memory.

---
 rtl/lsu_pkg.sv | 8 +
 rtl/load_store_sequencer_if.sv | 13 +
 rtl/lsu_extend.sv | 17 +
 rtl/load_store_sequencer.sv | 107 ++++++++++
 tb/tb_load_store_sequencer.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store sequencer.
package lsu_pkg;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  function automatic logic [3:0] nbytes(size_e s);
    return 4'd1 << s;
  endfunction
endpackage

// File: rtl/load_store_sequencer_if.sv
// load_store_sequencer_if: EX-side request/response handshake of the load/store sequencer.
interface load_store_sequencer_if #(parameter int ADDR_W = 64) ();
  import lsu_pkg::*;
  logic req_valid, req_ready, req_write, req_signed;
  size_e req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0] req_wdata, rsp_rdata;
  logic rsp_valid, rsp_err;
  modport master (output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
                  input req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave (input req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
                 output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/lsu_extend.sv
// lsu_extend: sign/zero-extends the low (1<<size) bytes of a load buffer to 64 bits.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [63:0] buffer,
  input  size_e       size,
  input  logic        sgn,
  output logic [63:0] result
);
  logic s;
  always_comb begin
    s = sgn & (size == SZ_B ? buffer[7] : size == SZ_H ? buffer[15] : size == SZ_W ? buffer[31] : buffer[63]);
    result = size == SZ_B ? {{56{s}}, buffer[7:0]} :
             size == SZ_H ? {{48{s}}, buffer[15:0]} :
             size == SZ_W ? {{32{s}}, buffer[31:0]} : buffer;
  end
endmodule

// File: rtl/load_store_sequencer.sv
// load_store_sequencer: serialises B/H/W/D accesses into little-endian byte memory cycles.
// Define MISALIGN_TRAP_EN to reject accesses whose address is not a multiple of their size.
module load_store_sequencer
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 32,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  load_store_sequencer_if.slave ls,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [7:0]        mem_datain,
  output logic              mem_w,
  output logic              mem_r,
  input  logic [7:0]        mem_dataout
);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_BYTES);
  state_e state;
  size_e size;
  logic write, sgn, bad;
  logic [2:0] cnt, nxt, last;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0] end_addr;
  logic [63:0] wdata, buffer, buf_next, ext;
  always_comb begin
    nxt = cnt + 3'd1;
    last = 3'(nbytes(size) - 4'd1);
    buf_next = buffer;
    buf_next[{cnt, 3'b000} +: 8] = mem_dataout;
    // one extra bit so an address near the top of the space cannot wrap past the check
    end_addr = {1'b0, ls.req_addr} + {{(ADDR_W-3){1'b0}}, nbytes(ls.req_size)};
    bad = end_addr > LIMIT;
`ifdef MISALIGN_TRAP_EN
    bad = bad | (|(ls.req_addr[2:0] & 3'(nbytes(ls.req_size) - 4'd1)));
`else
    bad = bad | 1'b0;
`endif
  end
  lsu_extend u_extend (.buffer(buf_next), .size(size), .sgn(sgn), .result(ext));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      write <= 1'b0;
      sgn <= 1'b0;
      size <= SZ_B;
      base <= '0;
      wdata <= '0;
      buffer <= '0;
      ls.req_ready <= 1'b1;
      ls.rsp_valid <= 1'b0;
      ls.rsp_rdata <= '0;
      ls.rsp_err <= 1'b0;
      mem_adr <= '0;
      mem_datain <= '0;
      mem_w <= 1'b0;
      mem_r <= 1'b0;
    end else
      case (state)
        IDLE: if (ls.req_valid) begin
          write <= ls.req_write;
          sgn <= ls.req_signed;
          size <= ls.req_size;
          base <= ls.req_addr;
          wdata <= ls.req_wdata;
          buffer <= '0;
          cnt <= '0;
          ls.req_ready <= 1'b0;
          if (bad) begin
            state <= RESP;
            ls.rsp_valid <= 1'b1;
            ls.rsp_err <= 1'b1;
            ls.rsp_rdata <= '0;
          end else begin
            state <= ACCESS;
            mem_adr <= ls.req_addr;
            mem_datain <= ls.req_wdata[7:0];
            mem_w <= ls.req_write;
            mem_r <= !ls.req_write;
          end
        end
        ACCESS: begin
          if (!write) buffer <= buf_next;
          if (cnt == last) begin
            state <= RESP;
            mem_adr <= '0;
            mem_datain <= '0;
            mem_w <= 1'b0;
            mem_r <= 1'b0;
            ls.rsp_valid <= 1'b1;
            ls.rsp_err <= 1'b0;
            ls.rsp_rdata <= write ? '0 : ext;
          end else begin
            cnt <= nxt;
            mem_adr <= base + {{(ADDR_W-3){1'b0}}, nxt};
            mem_datain <= wdata[{nxt, 3'b000} +: 8];
          end
        end
        default: begin
          state <= IDLE;
          ls.rsp_valid <= 1'b0;
          ls.rsp_err <= 1'b0;
          ls.req_ready <= 1'b1;
        end
      endcase
endmodule

// File: tb/tb_load_store_sequencer.sv
// tb_load_store_sequencer: directed bench with a byte-array reference model and per-cycle compare.
module tb_load_store_sequencer;
  import lsu_pkg::*;
  localparam int MEM_BYTES = 32;
  logic clk = 1'b0, reset = 1'b1;
  logic [63:0] mem_adr;
  logic [7:0] mem_datain, mem_dataout;
  logic mem_w, mem_r;
  logic [7:0] mem [MEM_BYTES] = '{default: 8'h00};
  logic [7:0] ref_mem [MEM_BYTES] = '{default: 8'h00};
  int n_vec = 0, n_bad = 0, cyc = 0, n_memr = 0, dut_rsp_cyc = -1;
  bit cur_active = 0, cur_err = 0, cur_w = 0;
  int cur_acc = 0, cur_nb = 1;
  logic [63:0] cur_addr = '0, cur_wd = '0, cur_rd = '0, last_rd = '0;

  load_store_sequencer_if #(.ADDR_W(64)) ls ();
  load_store_sequencer #(.MEM_BYTES(MEM_BYTES), .ADDR_W(64)) dut (
    .clk(clk), .reset(reset), .ls(ls), .mem_adr(mem_adr), .mem_datain(mem_datain),
    .mem_w(mem_w), .mem_r(mem_r), .mem_dataout(mem_dataout));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_w && mem_adr < 64'(MEM_BYTES)) mem[mem_adr[4:0]] <= mem_datain;
  assign mem_dataout = mem_adr < 64'(MEM_BYTES) ? mem[mem_adr[4:0]] : 8'h00;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected interface behaviour derived from the active request and the current cycle offset.
  always @(negedge clk)
    if (reset) last_rd = '0;
    else begin
      int k, lat;
      bit in_mem, in_rsp;
      logic [7:0] exp_din;
      k = cyc - cur_acc;
      lat = cur_err ? 0 : cur_nb;
      in_mem = cur_active && !cur_err && k >= 0 && k < cur_nb;
      in_rsp = cur_active && k == lat;
      exp_din = 8'h00;
      if (in_mem && cur_w) exp_din = cur_wd[8*k +: 8];
      chk("mem_w", 64'(mem_w), 64'(in_mem && cur_w));
      chk("mem_r", 64'(mem_r), 64'(in_mem && !cur_w));
      chk("mem_adr", mem_adr, in_mem ? cur_addr + 64'(k) : 64'd0);
      chk("mem_datain", 64'(mem_datain), 64'(exp_din));
      chk("rsp_valid", 64'(ls.rsp_valid), 64'(in_rsp));
      chk("req_ready", 64'(ls.req_ready), 64'(!(cur_active && k >= 0 && k <= lat)));
      if (in_rsp) begin
        last_rd = cur_rd;
        chk("rsp_err", 64'(ls.rsp_err), 64'(cur_err));
      end
      chk("rsp_rdata", ls.rsp_rdata, last_rd);
      if (ls.rsp_valid) dut_rsp_cyc = cyc;
      if (mem_r) n_memr++;
    end

  task automatic issue(input bit w, input int sz, input bit sg, input logic [63:0] addr, input logic [63:0] wd);
    int t = 0;
    int nb;
    while (ls.req_ready !== 1'b1 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("req_ready_wait", 64'(ls.req_ready), 64'd1);
    ls.req_write = w;
    ls.req_size = size_e'(sz[1:0]);
    ls.req_signed = sg;
    ls.req_addr = addr;
    ls.req_wdata = wd;
    ls.req_valid = 1'b1;
    @(posedge clk);
    #1;
    ls.req_valid = 1'b0;
    ls.req_write = ~w;
    ls.req_size = SZ_D;
    ls.req_addr = 64'h1F;
    ls.req_wdata = ~wd;
    nb = 1 << sz;
    cur_err = ({1'b0, addr} + 65'(nb)) > 65'(MEM_BYTES);
`ifdef MISALIGN_TRAP_EN
    if (addr % 64'(nb) != 0) cur_err = 1;
`endif
    cur_rd = '0;
    if (!cur_err)
      for (int i = 0; i < nb; i++)
        if (w) ref_mem[int'(addr[4:0]) + i] = wd[8*i +: 8];
        else cur_rd[8*i +: 8] = ref_mem[int'(addr[4:0]) + i];
    if (!cur_err && !w && sg && cur_rd[8*nb-1])
      for (int i = nb; i < 8; i++) cur_rd[8*i +: 8] = 8'hFF;
    cur_acc = cyc;
    cur_nb = nb;
    cur_w = w;
    cur_addr = addr;
    cur_wd = wd;
    cur_active = 1;
  endtask

  task automatic wait_done();
    int t = 0;
    while (cyc <= cur_acc + (cur_err ? 0 : cur_nb) && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("rsp_wait", 64'(t < 20), 64'd1);
    cur_active = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int m0;
    ls.req_valid = 1'b0;
    ls.req_write = 1'b0;
    ls.req_size = SZ_B;
    ls.req_signed = 1'b0;
    ls.req_addr = '0;
    ls.req_wdata = '0;
    @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(ls.req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(ls.rsp_valid), 64'd0);
    chk("rst_mem_w", 64'(mem_w), 64'd0);
    chk("rst_mem_r", 64'(mem_r), 64'd0);
    chk("rst_mem_adr", mem_adr, 64'd0);
    chk("rst_rsp_rdata", ls.rsp_rdata, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    // reset in the middle of a doubleword store, while byte 3 is on the bus
    issue(1, 3, 0, 64'd0, 64'hDEADBEEFCAFEF00D);
    while (cyc < cur_acc + 3) begin
      @(posedge clk);
      #1;
    end
    #2;
    reset = 1'b1;
    cur_active = 0;
    for (int i = 0; i < 3; i++) ref_mem[i] = cur_wd[8*i +: 8];
    #1;
    chk("abort_mem_w", 64'(mem_w), 64'd0);
    chk("abort_req_ready", 64'(ls.req_ready), 64'd1);
    chk("abort_rsp_valid", 64'(ls.rsp_valid), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_byte2", 64'(mem[2]), 64'h00000000000000FE);
    chk("abort_byte3", 64'(mem[3]), 64'd0);
    // doubleword store then signed doubleword load
    issue(1, 3, 0, 64'd0, 64'h8877665544332211);
    wait_done();
    for (int i = 0; i < 8; i++) chk("t2_mem_byte", 64'(mem[i]), 64'(8'h11 * 8'(i + 1)));
    issue(0, 3, 1, 64'd0, 64'h0);
    wait_done();
    chk("t2_rdata", ls.rsp_rdata, 64'h8877665544332211);
    chk("t2_latency", 64'(dut_rsp_cyc - cur_acc), 64'd8);
    // byte store back-to-back with signed and unsigned byte loads
    issue(1, 0, 0, 64'd5, 64'h123456789ABCDEF0);
    issue(0, 0, 1, 64'd5, 64'h0);
    wait_done();
    chk("t3_signed", ls.rsp_rdata, 64'hFFFFFFFFFFFFFFF0);
    chk("t3_latency", 64'(dut_rsp_cyc - cur_acc), 64'd1);
    issue(0, 0, 0, 64'd5, 64'h0);
    wait_done();
    chk("t3_unsigned", ls.rsp_rdata, 64'h00000000000000F0);
    // word load straddling the top of memory
    m0 = n_memr;
    issue(0, 2, 0, 64'd30, 64'h0);
    wait_done();
    chk("t4_model_err", 64'(cur_err), 64'd1);
    chk("t4_latency", 64'(dut_rsp_cyc - cur_acc), 64'd0);
    chk("t4_no_mem_r", 64'(n_memr - m0), 64'd0);
    // misaligned halfword load
    m0 = n_memr;
    issue(0, 1, 0, 64'd3, 64'h0);
    wait_done();
`ifdef MISALIGN_TRAP_EN
    chk("t5_model_err", 64'(cur_err), 64'd1);
    chk("t5_no_mem_r", 64'(n_memr - m0), 64'd0);
`else
    chk("t5_rdata", ls.rsp_rdata, 64'h0000000000005544);
    chk("t5_mem_r_cycles", 64'(n_memr - m0), 64'd2);
`endif
    // misaligned word load
    issue(0, 2, 0, 64'd1, 64'h0);
    wait_done();
`ifndef MISALIGN_TRAP_EN
    chk("mis_w_rdata", ls.rsp_rdata, 64'h0000000055443322);
`endif
    // upper boundary, out-of-range store and address-wrap rejection
    issue(1, 2, 0, 64'd28, 64'hFFFFFFFF89ABCDEF);
    issue(1, 3, 0, 64'd28, 64'h0102030405060708);
    wait_done();
    chk("oor_store_err", 64'(cur_err), 64'd1);
    issue(0, 2, 1, 64'd28, 64'h0);
    wait_done();
    chk("w_signed", ls.rsp_rdata, 64'hFFFFFFFF89ABCDEF);
    issue(0, 3, 0, 64'd24, 64'h0);
    wait_done();
    chk("d_top_rdata", ls.rsp_rdata, 64'h89ABCDEF00000000);
    issue(0, 3, 0, 64'd25, 64'h0);
    wait_done();
    issue(0, 1, 0, 64'hFFFFFFFFFFFFFFFE, 64'h0);
    wait_done();
    chk("wrap_model_err", 64'(cur_err), 64'd1);
    issue(1, 1, 0, 64'd6, 64'h0000000000008001);
    issue(0, 1, 1, 64'd6, 64'h0);
    wait_done();
    chk("h_signed", ls.rsp_rdata, 64'hFFFFFFFFFFFF8001);
    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
